// File: rtl/inv_softplus.sv
// Inverse softplus on signed Q7.8 samples: x = y - c(y), where c comes from a small correction table.
// Latency: 2 cycles from presentation (edge 1 loads S1, edge 2 loads S2); one sample per cycle sustained.
// Backpressure: S2 stalls while out_ready=0; S1 absorbs one more sample, then in_ready drops.
module inv_softplus #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1 state
  logic        s1_valid;
  logic [15:0] s1_y;
  logic [15:0] s1_c;
  logic        s1_err;

  // Input decode
  logic [6:0]  ipart;
  logic [1:0]  fpart;
  logic [15:0] corr;
  logic        dom_err;
  logic        ld2;
  logic        accept;
  logic [15:0] diff;
  logic [15:0] result;

  assign ipart   = in_data[14:8];
  assign fpart   = in_data[7:6];
  assign dom_err = in_data[15] | (in_data == 16'h0000);

  // S2 can take a new value when it is empty or is being drained this cycle
  assign ld2      = !out_valid || out_ready;
  assign in_ready = !s1_valid || ld2;
  assign accept   = in_valid && in_ready;

  // Correction term: fine steps below 1.0, coarse steps by integer part above, zero from 6.0 upward
  always_comb begin
    corr = 16'h0000;
    case (ipart)
      7'd0: begin
        case (fpart)
          2'd0:    corr = 16'h0224;
          2'd1:    corr = 16'h0129;
          2'd2:    corr = 16'h00C4;
          default: corr = 16'h008A;
        endcase
      end
      7'd1:    corr = 16'h0041;
      7'd2:    corr = 16'h0016;
      7'd3:    corr = 16'h0008;
      7'd4:    corr = 16'h0003;
      7'd5:    corr = 16'h0001;
      default: corr = 16'h0000;
    endcase
  end

  // A 16-bit wrapping subtract gives exactly the low 16 bits of the 17-bit signed difference;
  // legal (non-negative, non-zero) y never overflows, and errored samples are overridden anyway.
  assign diff   = s1_y - s1_c;
  assign result = s1_err ? 16'h8000 : diff;

  // Stage 1: capture operand, correction and error flag; empties when S2 takes the sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_y     <= 16'h0000;
      s1_c     <= 16'h0000;
      s1_err   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_y     <= in_data;
      s1_c     <= corr;
      s1_err   <= dom_err;
    end else if (ld2) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: registered result; holds steady while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_err   <= 1'b0;
    end else if (ld2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= result;
        out_err  <= s1_err;
      end
    end
  end

  // Saturating count of accepted domain-error samples; clear wins over a coincident increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (accept && dom_err && (err_count != CNT_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_inv_softplus.sv
`timescale 1ns/1ps
module tb_inv_softplus;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;
  logic        err_clr;
  logic [7:0]  err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  inv_softplus #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: correction by lookup over integer/fraction fields
  function automatic logic [16:0] model(input logic [15:0] y);
    logic [15:0] ftab [4];
    logic [15:0] itab [6];
    logic [15:0] c;
    logic [16:0] d;
    ftab = '{16'h0224, 16'h0129, 16'h00C4, 16'h008A};
    itab = '{16'h0000, 16'h0041, 16'h0016, 16'h0008, 16'h0003, 16'h0001};
    if (y[15] || y == 16'h0000) return {1'b1, 16'h8000};
    if (y[14:8] == 7'd0)      c = ftab[y[7:6]];
    else if (y[14:8] < 7'd6)  c = itab[y[10:8]];
    else                      c = 16'h0000;
    d = {y[15], y} - {1'b0, c};
    return {1'b0, d[15:0]};
  endfunction

  typedef struct {
    logic [15:0] y;
    logic [15:0] x;
    logic        e;
  } vec_t;

  vec_t tbl [14];
  logic [16:0] q [$];
  logic [16:0] exp_v;
  logic [15:0] ry;

  initial begin
    tbl[0]  = '{16'h0100, 16'h00BF, 1'b0};
    tbl[1]  = '{16'h0800, 16'h0800, 1'b0};
    tbl[2]  = '{16'h0280, 16'h026A, 1'b0};
    tbl[3]  = '{16'h0040, 16'hFF17, 1'b0};
    tbl[4]  = '{16'h00C0, 16'h0036, 1'b0};
    tbl[5]  = '{16'h0001, 16'hFDDD, 1'b0};
    tbl[6]  = '{16'h0080, 16'hFFBC, 1'b0};
    tbl[7]  = '{16'h0300, 16'h02F8, 1'b0};
    tbl[8]  = '{16'h0400, 16'h03FD, 1'b0};
    tbl[9]  = '{16'h0500, 16'h04FF, 1'b0};
    tbl[10] = '{16'h0600, 16'h0600, 1'b0};
    tbl[11] = '{16'h7FFF, 16'h7FFF, 1'b0};
    tbl[12] = '{16'h0000, 16'h8000, 1'b1};
    tbl[13] = '{16'hFF00, 16'h8000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b1; err_clr = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'b0, out_data}, 32'h0000);
    chk("rst_out_err",   {31'b0, out_err}, 32'd0);
    chk("rst_err_count", {24'b0, err_count}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);

    @(negedge clk);
    rst = 1'b0;

    // Table vectors, one at a time with out_ready high
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_data = tbl[i].y;
      chk($sformatf("tbl%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_not_yet", i), {31'b0, out_valid}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("tbl%0d_data", i), {16'b0, out_data}, {16'b0, tbl[i].x});
      chk($sformatf("tbl%0d_err", i), {31'b0, out_err}, {31'b0, tbl[i].e});
    end
    chk("errcnt_two", {24'b0, err_count}, 32'd2);

    // Clear coincident with a third error input: clear wins
    in_valid = 1'b1; in_data = 16'h8000; err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; err_clr = 1'b0;
    chk("errclr_priority", {24'b0, err_count}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("errclr_sample_data", {16'b0, out_data}, 32'h8000);
    chk("errclr_sample_err", {31'b0, out_err}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("drained", {31'b0, out_valid}, 32'd0);

    // Backpressure: two samples fill the pipe, the third waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0100;
    @(posedge clk); @(negedge clk);
    chk("bp_rdy_after1", {31'b0, in_ready}, 32'd1);
    in_data = 16'h0200;
    @(posedge clk); @(negedge clk);
    in_data = 16'h0300;
    chk("bp_rdy_after2", {31'b0, in_ready}, 32'd0);
    chk("bp_data0", {16'b0, out_data}, 32'h00BF);
    @(posedge clk); @(negedge clk);
    chk("bp_rdy_stall", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_hold_data", {16'b0, out_data}, 32'h00BF);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", {31'b0, in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("bp_data1", {16'b0, out_data}, 32'h01EA);
    @(posedge clk); @(negedge clk);
    chk("bp_valid2", {31'b0, out_valid}, 32'd1);
    chk("bp_data2", {16'b0, out_data}, 32'h02F8);
    @(posedge clk); @(negedge clk);
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Random valid/ready stream against the model, with saturation of the error counter
    begin
      int sent = 0, recv = 0, cyc = 0, nerr = 0;
      logic pend = 1'b0;
      ry = 16'h0000;
      err_clr = 1'b1;
      @(posedge clk); @(negedge clk);
      err_clr = 1'b0;
      while ((sent < 10000 || recv < 10000) && cyc < 60000) begin
        cyc++;
        if (!pend && sent < 10000 && $urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 7))
            0:       ry = ($urandom_range(0, 1) != 0) ? 16'h0000 : (16'h8000 | 16'($urandom_range(0, 32767)));
            1, 2, 3: ry = 16'($urandom_range(1, 16'h07FF));
            default: ry = 16'($urandom_range(1, 32767));
          endcase
          pend = 1'b1;
        end
        in_valid  = pend;
        in_data   = ry;
        out_ready = ($urandom_range(0, 3) != 0);
        #2;
        if (in_valid && in_ready) begin
          q.push_back(model(ry));
          if (model(ry) == {1'b1, 16'h8000}) nerr++;
          pend = 1'b0;
          sent++;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("rnd_unexpected_output", 32'd1, 32'd0);
          end else begin
            exp_v = q.pop_front();
            chk($sformatf("rnd_out%0d", recv), {15'b0, out_err, out_data}, {15'b0, exp_v});
          end
          recv++;
        end
        @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("rnd_timeout", {31'b0, (cyc >= 60000)}, 32'd0);
      chk("rnd_enough_errs", {31'b0, (nerr >= 300)}, 32'd1);
      chk("rnd_errcnt_sat", {24'b0, err_count}, 32'hFF);
    end
    @(posedge clk); @(negedge clk);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0000; err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
    @(posedge clk); @(negedge clk);
    in_data = 16'h0100;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("ar_full_valid", {31'b0, out_valid}, 32'd1);
    chk("ar_full_rdy", {31'b0, in_ready}, 32'd0);
    chk("ar_errcnt_before", {24'b0, err_count}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_err_count", {24'b0, err_count}, 32'd0);
    chk("ar_in_ready", {31'b0, in_ready}, 32'd1);
    chk("ar_out_data", {16'b0, out_data}, 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0280;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("ar_post_not_yet", {31'b0, out_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("ar_post_valid", {31'b0, out_valid}, 32'd1);
    chk("ar_post_data", {16'b0, out_data}, 32'h026A);
    chk("ar_post_err", {31'b0, out_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_softplus.md
INV_SOFTPLUS -- requirements
Module: inv_softplus

Interface
REQ-001 Parameter CNT_W, default 8, width of the domain-error counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  in_data holds a sample.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 in_data  input  16  operand y, signed Q7.8 (bit 15 sign, [14:8] integer, [7:0] fraction).
REQ-007 out_valid  output  1  out_data/out_err hold a result.
REQ-008 out_ready  input  1  downstream consumes result this cycle.
REQ-009 out_data  output  16  x = inverse softplus of y, signed Q7.8.
REQ-010 out_err  output  1  result belongs to a domain-error input.
REQ-011 err_clr  input  1  synchronous clear of err_count.
REQ-012 err_count  output  CNT_W  saturating count of accepted domain-error inputs.

Function
REQ-013 Transfer occurs on a port when valid and ready are both high at a rising clk edge.
REQ-014 Result x = y - c, where c is the correction term selected by REQ-015; computed in 17-bit signed arithmetic and truncated to 16 bits (no overflow is possible for legal y).
REQ-015 Correction c by y[14:8] (i) and y[7:6] (f): i=0,f=0 -> 0x0224; i=0,f=1 -> 0x0129; i=0,f=2 -> 0x00C4; i=0,f=3 -> 0x008A; i=1 -> 0x0041; i=2 -> 0x0016; i=3 -> 0x0008; i=4 -> 0x0003; i=5 -> 0x0001; i>=6 -> 0x0000.
REQ-016 Domain error: y[15]=1 or y=0x0000; result out_data=0x8000, out_err=1; all other inputs give out_err=0.
REQ-017 Two-stage pipeline: stage S1 registers y, c and the error flag; stage S2 registers out_data, out_err, out_valid.
REQ-018 S2 load enable ld2 = !out_valid || out_ready; S1 advances into S2 when s1_valid && ld2.
REQ-019 in_ready = !s1_valid || ld2 (combinational; no dependency on in_valid).
REQ-020 Latency: a sample accepted at edge N appears with out_valid=1 after edge N+2 when out_ready stays high.
REQ-021 Throughput: one sample per cycle under continuous out_ready=1; no bubbles inserted.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_err hold stable; at most 2 samples are held in flight; in-order delivery, no loss or duplication.
REQ-023 out_valid clears after a consuming transfer only if S1 holds no valid sample.
REQ-024 err_count increments by 1 on each accepted input meeting REQ-016; it holds at 2^CNT_W-1 (no wrap).
REQ-025 err_clr=1 sets err_count to 0 at the next edge; this has priority over a coincident increment (that error is not counted).

Reset
REQ-026 rst=1 immediately forces s1_valid=0, out_valid=0, out_data=0x0000, out_err=0, err_count=0; in-flight samples are discarded.
REQ-027 During rst=1, in_ready=1 (pipeline empty); no transfer completes while rst=1.
REQ-028 First accept is possible at the first rising edge after rst deasserts.

Verification
REQ-029 y=0x0100, out_ready=1 -> two edges later out_data=0x00BF, out_err=0; y=0x0800 -> 0x0800; y=0x0280 -> 0x026A.
REQ-030 y=0x0040 -> out_data=0xFF17; y=0x00C0 -> 0x0036; y=0x0001 -> 0xFDDD; all out_err=0.
REQ-031 y=0x0000 then y=0xFF00 -> out_data=0x8000, out_err=1 twice; err_count=2; err_clr pulse coincident with a third error input -> err_count=0.
REQ-032 Stream 0x0100,0x0200,0x0300 with out_ready=0 -> in_ready low after 2 accepts, out_data held at 0x00BF; on out_ready=1 the outputs are 0x00BF,0x01EA,0x02F8 in order, then the third sample is accepted.
REQ-033 Random valid/ready toggling, 10k samples vs. table model -> exact match, no drops; 300 error inputs with CNT_W=8 -> err_count=0xFF.
REQ-034 rst asserted mid-stream with both stages full -> out_valid=0, err_count=0 asynchronously, before the next edge; first post-reset sample gives correct result at latency 2.
